// File: rtl/indec_ext.sv
// indec_ext: assembles a UART byte stream into short/long commands with back-pressure and an inter-byte timeout
module indec_ext #(
  parameter int DATA_W     = 8,
  parameter int LONG_BYTES = 4,
  parameter int TIMEOUT    = 1000
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [DATA_W-1:0]            rx_data_i,
  input  logic                         rx_valid_i,
  output logic                         rx_ready_o,
  output logic [DATA_W-1:0]            cmd_o,
  output logic [LONG_BYTES*DATA_W-1:0] arg_o,
  output logic                         cmd_long_o,
  output logic                         cmd_valid_o,
  input  logic                         cmd_ready_i,
  output logic                         timeout_o,
  output logic                         busy_o
);
  localparam int CW = $clog2(LONG_BYTES + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(LONG_BYTES - 1);
  localparam logic [TW-1:0] TLIM = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  typedef enum logic [1:0] {IDLE, ARGS, HOLD} state_t;
  state_t                       state_q;
  logic [CW-1:0]                cnt_q;
  logic [TW-1:0]                tcnt_q;
  logic [DATA_W-1:0]            cmd_q;
  logic [LONG_BYTES*DATA_W-1:0] arg_q;
  logic                         long_q, valid_q, tout_q, busy_q;
  logic                         acc, expire;
  assign rx_ready_o  = state_q != HOLD;
  assign acc         = rx_valid_i && rx_ready_o;
  // an accept in the expiry cycle wins over the timeout
  assign expire      = (TIMEOUT > 0) && !acc && tcnt_q == TLIM;
  assign cmd_o       = cmd_q;
  assign arg_o       = arg_q;
  assign cmd_long_o  = long_q;
  assign cmd_valid_o = valid_q;
  assign timeout_o   = tout_q;
  assign busy_o      = busy_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      cmd_q   <= '0;
      arg_q   <= '0;
      long_q  <= 1'b0;
      valid_q <= 1'b0;
      tout_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      tout_q <= 1'b0;
      case (state_q)
        IDLE: if (acc) begin
          cmd_q   <= rx_data_i;
          arg_q   <= '0;
          long_q  <= rx_data_i[DATA_W-1];
          cnt_q   <= '0;
          tcnt_q  <= '0;
          valid_q <= !rx_data_i[DATA_W-1];
          busy_q  <= rx_data_i[DATA_W-1];
          state_q <= rx_data_i[DATA_W-1] ? ARGS : HOLD;
        end
        ARGS: if (acc) begin
          for (int i = 0; i < LONG_BYTES; i++)
            if (cnt_q == CW'(i)) arg_q[i*DATA_W +: DATA_W] <= rx_data_i;
          cnt_q  <= cnt_q + 1'b1;
          tcnt_q <= '0;
          if (cnt_q == LAST) begin
            state_q <= HOLD;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end else if (expire) begin
          state_q <= IDLE;
          cnt_q   <= '0;
          tcnt_q  <= '0;
          long_q  <= 1'b0;
          busy_q  <= 1'b0;
          tout_q  <= 1'b1;
        end else if (TIMEOUT > 0) begin
          tcnt_q <= tcnt_q + TW'(tcnt_q != '1);
        end
        HOLD: if (cmd_ready_i) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_indec_ext.sv
// tb_indec_ext: directed checks of command assembly, back-pressure, timeout and reset
module tb_indec_ext;
  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0, rx_ready;
  logic [7:0]  cmd;
  logic [31:0] arg;
  logic        cmd_long, cmd_valid, cmd_ready = 1'b0, tout, busy;
  int          checks = 0, failures = 0;

  indec_ext #(.DATA_W(8), .LONG_BYTES(4), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .rx_ready_o(rx_ready), .cmd_o(cmd), .arg_o(arg), .cmd_long_o(cmd_long),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .timeout_o(tout), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic release_cmd();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if ({cmd_valid, cmd_long, busy, tout, rx_ready} !== 5'b00001) begin
      failures++;
      $display("FAIL reset_flags got %b want 00001", {cmd_valid, cmd_long, busy, tout, rx_ready});
    end
    checks++;
    if ({cmd, arg} !== 40'h0) begin
      failures++;
      $display("FAIL reset_data got %h want 0", {cmd, arg});
    end
  endtask

  task automatic test_short();
    send(8'h00);
    checks++;
    if ({cmd_valid, cmd_long, rx_ready} !== 3'b100 || cmd !== 8'h00 || arg !== 32'h0) begin
      failures++;
      $display("FAIL short_cmd got v/l/r=%b cmd=%h arg=%h want 100 00 0", {cmd_valid, cmd_long, rx_ready}, cmd, arg);
    end
    release_cmd();
    checks++;
    if ({cmd_valid, rx_ready} !== 2'b01) begin
      failures++;
      $display("FAIL short_release got v/r=%b want 01", {cmd_valid, rx_ready});
    end
  endtask

  task automatic test_long();
    logic [7:0] bytes [5];
    bytes = '{8'hC0, 8'h11, 8'h22, 8'h33, 8'h44};
    rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_data = bytes[i];
      step();
      checks++;
      if ({cmd_valid, busy, cmd_long} !== 3'b011 || cmd !== 8'hC0) begin
        failures++;
        $display("FAIL long_busy byte%0d got v/b/l=%b cmd=%h want 011 c0", i, {cmd_valid, busy, cmd_long}, cmd);
      end
    end
    rx_data = bytes[4];
    step();
    rx_valid = 1'b0;
    checks++;
    if ({cmd_valid, busy, cmd_long} !== 3'b101 || cmd !== 8'hC0 || arg !== 32'h44332211) begin
      failures++;
      $display("FAIL long_done got v/b/l=%b cmd=%h arg=%h want 101 c0 44332211", {cmd_valid, busy, cmd_long}, cmd, arg);
    end
    release_cmd();
  endtask

  task automatic test_back_pressure();
    int bad = 0;
    send(8'h05);
    rx_valid = 1'b1;
    rx_data  = 8'h02;
    for (int i = 0; i < 20; i++) begin
      step();
      if ({rx_ready, cmd_valid} !== 2'b01 || cmd !== 8'h05 || arg !== 32'h0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hold_stable got %0d bad cycles want 0", bad);
    end
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    checks++;
    if ({rx_ready, cmd_valid} !== 2'b10) begin
      failures++;
      $display("FAIL hold_release got r/v=%b want 10", {rx_ready, cmd_valid});
    end
    step();
    rx_valid = 1'b0;
    checks++;
    if (cmd_valid !== 1'b1 || cmd !== 8'h02 || cmd_long !== 1'b0) begin
      failures++;
      $display("FAIL next_short got v=%b cmd=%h l=%b want 1 02 0", cmd_valid, cmd, cmd_long);
    end
    release_cmd();
  endtask

  task automatic test_timeout();
    int bad = 0;
    send(8'h80);
    send(8'hAA);
    for (int i = 1; i < 8; i++) begin
      step();
      if ({tout, busy} !== 2'b01) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL timeout_early got %0d bad cycles want 0", bad);
    end
    step();
    checks++;
    if ({tout, busy, cmd_long, rx_ready, cmd_valid} !== 5'b10010) begin
      failures++;
      $display("FAIL timeout_pulse got t/b/l/r/v=%b want 10010", {tout, busy, cmd_long, rx_ready, cmd_valid});
    end
    step();
    checks++;
    if (tout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_width got %b want 0", tout);
    end
    send(8'h01);
    checks++;
    if (cmd_valid !== 1'b1 || cmd !== 8'h01 || cmd_long !== 1'b0) begin
      failures++;
      $display("FAIL after_timeout got v=%b cmd=%h l=%b want 1 01 0", cmd_valid, cmd, cmd_long);
    end
    release_cmd();
  endtask

  task automatic test_expiry_accept();
    send(8'h80);
    send(8'hAA);
    for (int i = 0; i < 7; i++) step();
    send(8'hBB);
    checks++;
    if ({tout, busy} !== 2'b01) begin
      failures++;
      $display("FAIL expiry_accept got t/b=%b want 01", {tout, busy});
    end
    send(8'hCC);
    send(8'hDD);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_long !== 1'b1 || cmd !== 8'h80 || arg !== 32'hDDCCBBAA) begin
      failures++;
      $display("FAIL expiry_cmd got v=%b l=%b cmd=%h arg=%h want 1 1 80 ddccbbaa", cmd_valid, cmd_long, cmd, arg);
    end
    release_cmd();
  endtask

  task automatic test_reset_mid();
    send(8'h90);
    send(8'h01);
    send(8'h02);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({cmd_valid, cmd_long, busy, tout, rx_ready} !== 5'b00001 || {cmd, arg} !== 40'h0) begin
      failures++;
      $display("FAIL reset_mid got flags=%b data=%h want 00001 0", {cmd_valid, cmd_long, busy, tout, rx_ready}, {cmd, arg});
    end
    step();
    checks++;
    if ({cmd_valid, tout} !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid_quiet got v/t=%b want 00", {cmd_valid, tout});
    end
    send(8'h11);
    checks++;
    if (cmd_valid !== 1'b1 || cmd !== 8'h11 || cmd_long !== 1'b0 || arg !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_next got v=%b cmd=%h l=%b arg=%h want 1 11 0 0", cmd_valid, cmd, cmd_long, arg);
    end
    release_cmd();
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_back_pressure();
    test_timeout();
    test_expiry_accept();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
